// File: rtl/m2_idct_block_scheduler_if.sv
// Handshake and addressing bundle between the IDCT block scheduler and its four engines.
interface m2_idct_block_scheduler_if;
  logic        fs_start, ct_start, cs_start, ws_start;
  logic        fs_done, ct_done, cs_done, ws_done;
  logic [17:0] fs_block_addr;
  logic [8:0]  fs_row_stride;
  logic        fs_is_y;
  logic [17:0] ws_block_addr;
  logic [8:0]  ws_row_stride;
  logic        sram_owner;
  logic        dp_bank;

  modport master (
    output fs_start, ct_start, cs_start, ws_start,
    output fs_block_addr, fs_row_stride, fs_is_y,
    output ws_block_addr, ws_row_stride, sram_owner, dp_bank,
    input  fs_done, ct_done, cs_done, ws_done
  );

  modport slave (
    input  fs_start, ct_start, cs_start, ws_start,
    input  fs_block_addr, fs_row_stride, fs_is_y,
    input  ws_block_addr, ws_row_stride, sram_owner, dp_bank,
    output fs_done, ct_done, cs_done, ws_done
  );
endinterface

// File: rtl/m2_idct_block_scheduler.sv
// Milestone 2 IDCT block sequencer: overlaps Fetch/ComputeT/ComputeS/Write engines
// in two alternating phases and generates per-engine SRAM block addresses.
module m2_idct_block_scheduler #(
  parameter int unsigned Y_COLS      = 40,
  parameter int unsigned Y_ROWS      = 30,
  parameter int unsigned C_COLS      = 20,
  parameter int unsigned C_ROWS      = 30,
  parameter int unsigned PRE_BASE    = 76800,
  parameter int unsigned U_POST_BASE = 38400,
  parameter int unsigned V_POST_BASE = 57600
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic Enable,
  m2_idct_block_scheduler_if.master eng,
  output logic busy,
  output logic done
);
  localparam int unsigned ADDR_W = 18;
  localparam int unsigned STR_W  = 9;
  localparam int unsigned COL_W  = $clog2((Y_COLS > C_COLS) ? Y_COLS : C_COLS);
  localparam int unsigned ROW_W  = $clog2((Y_ROWS > C_ROWS) ? Y_ROWS : C_ROWS);
  localparam int unsigned N_BLK  = Y_COLS * Y_ROWS + 2 * C_COLS * C_ROWS;
  localparam int unsigned CNT_W  = $clog2(N_BLK + 1);

  localparam logic [ADDR_W-1:0] Y_PRE   = ADDR_W'(PRE_BASE);
  localparam logic [ADDR_W-1:0] U_PRE   = ADDR_W'(PRE_BASE + 64 * Y_COLS * Y_ROWS);
  localparam logic [ADDR_W-1:0] V_PRE   = ADDR_W'(PRE_BASE + 64 * Y_COLS * Y_ROWS + 64 * C_COLS * C_ROWS);
  localparam logic [ADDR_W-1:0] U_POST  = ADDR_W'(U_POST_BASE);
  localparam logic [ADDR_W-1:0] V_POST  = ADDR_W'(V_POST_BASE);
  localparam logic [ADDR_W-1:0] FSTEP_Y = ADDR_W'(64 * Y_COLS);
  localparam logic [ADDR_W-1:0] FSTEP_C = ADDR_W'(64 * C_COLS);
  localparam logic [ADDR_W-1:0] WSTEP_Y = ADDR_W'(32 * Y_COLS);
  localparam logic [ADDR_W-1:0] WSTEP_C = ADDR_W'(32 * C_COLS);

  typedef enum logic [2:0] {S_IDLE, S_LI_FS, S_LI_CT, S_MA, S_MB, S_LO_WS} state_t;
  typedef enum logic [1:0] {P_Y, P_U, P_V} plane_t;

  // Fetch cursor: next block to fetch, with row-start anchors for incremental addressing.
  typedef struct packed {
    plane_t              plane;
    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic [ADDR_W-1:0]   fa, fra, wa, wra;
  } cursor_t;

  typedef struct packed {
    plane_t            plane;
    logic [ADDR_W-1:0] wa;
  } desc_t;

  function automatic cursor_t cur_start();
    cursor_t c;
    c       = '0;
    c.plane = P_Y;
    c.fa    = Y_PRE;
    c.fra   = Y_PRE;
    return c;
  endfunction

  function automatic cursor_t cur_advance(input cursor_t c);
    cursor_t n;
    logic    y;
    n = c;
    y = (c.plane == P_Y);
    if (c.col != (y ? COL_W'(Y_COLS - 1) : COL_W'(C_COLS - 1))) begin
      n.col = c.col + COL_W'(1);
      n.fa  = c.fa + ADDR_W'(8);
      n.wa  = c.wa + ADDR_W'(4);
    end else begin
      n.col = '0;
      if (c.row != (y ? ROW_W'(Y_ROWS - 1) : ROW_W'(C_ROWS - 1))) begin
        n.row = c.row + ROW_W'(1);
        n.fra = c.fra + (y ? FSTEP_Y : FSTEP_C);
        n.wra = c.wra + (y ? WSTEP_Y : WSTEP_C);
      end else begin
        n.row = '0;
        case (c.plane)
          P_Y:     begin n.plane = P_U; n.fra = U_PRE; n.wra = U_POST; end
          P_U:     begin n.plane = P_V; n.fra = V_PRE; n.wra = V_POST; end
          default: begin n.plane = P_Y; n.fra = Y_PRE; n.wra = '0;     end
        endcase
      end
      n.fa = n.fra;
      n.wa = n.wra;
    end
    return n;
  endfunction

  state_t              state_q, state_d;
  logic [3:0]          pend_q, pend_d, start_q, start_d, done_in;
  logic                ma_fs_q, ma_fs_d;
  logic [CNT_W-1:0]    fcnt_q, fcnt_d;
  cursor_t             cur_q, cur_d, cur_sel;
  desc_t               desc_f_q, desc_f_d, desc_c_q, desc_c_d;
  logic [ADDR_W-1:0]   fs_block_addr_q, fs_block_addr_d, ws_block_addr_q, ws_block_addr_d;
  logic [STR_W-1:0]    fs_row_stride_q, fs_row_stride_d, ws_row_stride_q, ws_row_stride_d;
  logic                fs_is_y_q, fs_is_y_d, sram_owner_q, sram_owner_d;
  logic                dp_bank_q, dp_bank_d, busy_q, busy_d, done_q, done_d;
  logic                enter, issue_fs, issue_ct, issue_cs, issue_ws;

  assign done_in = {eng.ws_done, eng.cs_done, eng.ct_done, eng.fs_done};

  // Phase sequencing: a state ends on the edge its last pending engine reports done.
  always_comb begin
    state_d         = state_q;
    pend_d          = pend_q & ~done_in;
    start_d         = '0;
    ma_fs_d         = ma_fs_q;
    fcnt_d          = fcnt_q;
    cur_d           = cur_q;
    cur_sel         = cur_q;
    desc_f_d        = desc_f_q;
    desc_c_d        = desc_c_q;
    fs_block_addr_d = fs_block_addr_q;
    fs_row_stride_d = fs_row_stride_q;
    fs_is_y_d       = fs_is_y_q;
    ws_block_addr_d = ws_block_addr_q;
    ws_row_stride_d = ws_row_stride_q;
    sram_owner_d    = sram_owner_q;
    dp_bank_d       = dp_bank_q;
    done_d          = 1'b0;
    issue_fs        = 1'b0;
    issue_ct        = 1'b0;
    issue_cs        = 1'b0;
    issue_ws        = 1'b0;

    case (state_q)
      S_IDLE:  if (Enable)         state_d = S_LI_FS;
      S_LI_FS: if (pend_d == '0)   state_d = S_LI_CT;
      S_LI_CT: if (pend_d == '0)   state_d = S_MA;
      S_MA:    if (pend_d == '0)   state_d = ma_fs_q ? S_MB : S_LO_WS;
      S_MB:    if (pend_d == '0)   state_d = S_MA;
      S_LO_WS: if (pend_d == '0) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    enter = (state_d != state_q);
    if (enter) begin
      if (state_d == S_LI_FS) cur_sel = cur_start();
      issue_fs = (state_d == S_LI_FS) || ((state_d == S_MA) && (fcnt_q != CNT_W'(N_BLK)));
      issue_ct = (state_d == S_LI_CT) || (state_d == S_MB);
      issue_cs = (state_d == S_MA);
      issue_ws = (state_d == S_MB) || (state_d == S_LO_WS);
      start_d  = {issue_ws, issue_cs, issue_ct, issue_fs};
      pend_d   = start_d;
      sram_owner_d = (state_d == S_MB) || (state_d == S_LO_WS);
      if (state_d == S_MA) ma_fs_d = issue_fs;
      if (issue_ct) desc_c_d = desc_f_q;
      if (issue_fs) begin
        fs_block_addr_d = cur_sel.fa;
        fs_is_y_d       = (cur_sel.plane == P_Y);
        fs_row_stride_d = (cur_sel.plane == P_Y) ? STR_W'(8 * Y_COLS) : STR_W'(8 * C_COLS);
        dp_bank_d       = ~dp_bank_q;
        desc_f_d        = '{plane: cur_sel.plane, wa: cur_sel.wa};
        cur_d           = cur_advance(cur_sel);
        fcnt_d          = (state_d == S_LI_FS) ? CNT_W'(1) : fcnt_q + CNT_W'(1);
      end
      // The write descriptor is held directly in the ws_* output registers.
      if (issue_ws) begin
        ws_block_addr_d = desc_c_q.wa;
        ws_row_stride_d = (desc_c_q.plane == P_Y) ? STR_W'(4 * Y_COLS) : STR_W'(4 * C_COLS);
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q         <= S_IDLE;
      pend_q          <= '0;
      start_q         <= '0;
      ma_fs_q         <= 1'b0;
      fcnt_q          <= '0;
      cur_q           <= '0;
      desc_f_q        <= '0;
      desc_c_q        <= '0;
      fs_block_addr_q <= '0;
      fs_row_stride_q <= '0;
      fs_is_y_q       <= 1'b0;
      ws_block_addr_q <= '0;
      ws_row_stride_q <= '0;
      sram_owner_q    <= 1'b0;
      dp_bank_q       <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      pend_q          <= pend_d;
      start_q         <= start_d;
      ma_fs_q         <= ma_fs_d;
      fcnt_q          <= fcnt_d;
      cur_q           <= cur_d;
      desc_f_q        <= desc_f_d;
      desc_c_q        <= desc_c_d;
      fs_block_addr_q <= fs_block_addr_d;
      fs_row_stride_q <= fs_row_stride_d;
      fs_is_y_q       <= fs_is_y_d;
      ws_block_addr_q <= ws_block_addr_d;
      ws_row_stride_q <= ws_row_stride_d;
      sram_owner_q    <= sram_owner_d;
      dp_bank_q       <= dp_bank_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign eng.fs_start      = start_q[0];
  assign eng.ct_start      = start_q[1];
  assign eng.cs_start      = start_q[2];
  assign eng.ws_start      = start_q[3];
  assign eng.fs_block_addr = fs_block_addr_q;
  assign eng.fs_row_stride = fs_row_stride_q;
  assign eng.fs_is_y       = fs_is_y_q;
  assign eng.ws_block_addr = ws_block_addr_q;
  assign eng.ws_row_stride = ws_row_stride_q;
  assign eng.sram_owner    = sram_owner_q;
  assign eng.dp_bank       = dp_bank_q;
  assign busy              = busy_q;
  assign done              = done_q;
endmodule

// File: tb/tb_m2_idct_block_scheduler.sv
// Directed bench for the IDCT block scheduler: engine responders plus an address scoreboard.
module tb_m2_idct_block_scheduler;
  logic Clock, Resetn, Enable, busy, done;
  m2_idct_block_scheduler_if eng();

  m2_idct_block_scheduler dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .Enable(Enable),
    .eng   (eng),
    .busy  (busy),
    .done  (done)
  );

  typedef struct packed {
    logic [17:0] fa;
    logic [8:0]  fstr;
    logic        y;
    logic [17:0] wa;
    logic [8:0]  wstr;
  } exp_t;

  exp_t fs_q[$];
  exp_t ws_q[$];
  int   pass_cnt = 0, tot_cnt = 0, fail_cnt = 0;
  int   cyc = 0;
  int   dly[4];
  int   st_cnt[4] = '{0, 0, 0, 0};
  int   done_cnt = 0;
  int   inj_req = 0;
  logic [3:0] st;

  assign st = {eng.ws_start, eng.cs_start, eng.ct_start, eng.fs_start};

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial forever begin
    @(posedge Clock);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Independent block-index model of fetch/write addresses.
  function automatic exp_t model(input int b);
    exp_t e;
    int   col, row, bb;
    if (b < 1200) begin
      col = b % 40; row = b / 40;
      e.fa = 18'(76800 + row * 2560 + col * 8);  e.fstr = 9'd320; e.y = 1'b1;
      e.wa = 18'(row * 1280 + col * 4);          e.wstr = 9'd160;
    end else if (b < 1800) begin
      bb = b - 1200; col = bb % 20; row = bb / 20;
      e.fa = 18'(153600 + row * 1280 + col * 8); e.fstr = 9'd160; e.y = 1'b0;
      e.wa = 18'(38400 + row * 640 + col * 4);   e.wstr = 9'd80;
    end else begin
      bb = b - 1800; col = bb % 20; row = bb / 20;
      e.fa = 18'(192000 + row * 1280 + col * 8); e.fstr = 9'd160; e.y = 1'b0;
      e.wa = 18'(57600 + row * 640 + col * 4);   e.wstr = 9'd80;
    end
    return e;
  endfunction

  task automatic push_run(input int n);
    for (int b = 0; b < n; b++) begin
      fs_q.push_back(model(b));
      ws_q.push_back(model(b));
    end
  endtask

  // Engine responders: done arrives dly[e] cycles after the start cycle.
  initial begin
    int   rem[4];
    int   inj_seen;
    logic [3:0] dn;
    rem = '{-1, -1, -1, -1};
    inj_seen = 0;
    eng.fs_done = 1'b0; eng.ct_done = 1'b0; eng.cs_done = 1'b0; eng.ws_done = 1'b0;
    forever begin
      @(negedge Clock);
      dn = '0;
      for (int e = 0; e < 4; e++) begin
        if (rem[e] > 0) rem[e]--;
        if (rem[e] == 0) begin dn[e] = 1'b1; rem[e] = -1; end
        if (st[e]) rem[e] = dly[e];
      end
      if (inj_req != inj_seen) begin dn[0] = 1'b1; inj_seen = inj_req; end
      eng.fs_done = dn[0]; eng.ct_done = dn[1]; eng.cs_done = dn[2]; eng.ws_done = dn[3];
    end
  end

  // Scoreboard monitor: pops expected descriptors on each FS / WS start.
  initial begin
    logic exp_bank;
    exp_t e;
    exp_bank = 1'b0;
    forever begin
      @(negedge Clock);
      if (!Resetn) exp_bank = 1'b0;
      else begin
        for (int i = 0; i < 4; i++) if (st[i]) st_cnt[i]++;
        if (done) done_cnt++;
        if (eng.fs_start) begin
          exp_bank = ~exp_bank;
          chk("fs_bank", 32'(eng.dp_bank), 32'(exp_bank));
          chk("fs_owner", 32'(eng.sram_owner), 32'd0);
          if (fs_q.size() == 0) chk("fs_unexpected", 32'd1, 32'd0);
          else begin
            e = fs_q.pop_front();
            chk("fs_addr", 32'(eng.fs_block_addr), 32'(e.fa));
            chk("fs_stride", 32'(eng.fs_row_stride), 32'(e.fstr));
            chk("fs_is_y", 32'(eng.fs_is_y), 32'(e.y));
          end
        end
        if (eng.ws_start) begin
          chk("ws_owner", 32'(eng.sram_owner), 32'd1);
          if (ws_q.size() == 0) chk("ws_unexpected", 32'd1, 32'd0);
          else begin
            e = ws_q.pop_front();
            chk("ws_addr", 32'(eng.ws_block_addr), 32'(e.wa));
            chk("ws_stride", 32'(eng.ws_row_stride), 32'(e.wstr));
          end
        end
      end
    end
  end

  task automatic wait_start(input int e, input string tag, output int c);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (st[e]) begin seen = 1'b1; break; end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    c = cyc;
  endtask

  task automatic pulse_enable();
    @(negedge Clock); Enable = 1'b1;
    @(negedge Clock); Enable = 1'b0;
  endtask

  initial begin
    int  t0, t1, t2, t3;
    bit  seen;
    Resetn = 1'b0; Enable = 1'b0;
    dly = '{5, 5, 5, 5};
    repeat (3) @(negedge Clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_starts", 32'(st), 32'd0);
    chk("rst_fs_addr", 32'(eng.fs_block_addr), 32'd0);
    chk("rst_ws_addr", 32'(eng.ws_block_addr), 32'd0);
    chk("rst_bank_owner", 32'({eng.dp_bank, eng.sram_owner}), 32'd0);
    Resetn = 1'b1;
    @(negedge Clock);

    // Full run with 5-cycle engines
    push_run(2400);
    pulse_enable();
    chk("first_fs_start", 32'(st), 32'd1);
    chk("first_fs_addr", 32'(eng.fs_block_addr), 32'd76800);
    chk("first_fs_stride", 32'(eng.fs_row_stride), 32'd320);
    chk("busy_running", 32'(busy), 32'd1);
    t0 = cyc;
    wait_start(1, "ct0", t1);
    chk("ct0_gap", 32'(t1 - t0), 32'd6);
    chk("ct0_bank", 32'(eng.dp_bank), 32'd1);
    wait_start(2, "cs0", t2);
    chk("cs0_gap", 32'(t2 - t1), 32'd6);
    chk("cs0_with_fs", 32'(st), 32'b0101);
    chk("fs1_addr", 32'(eng.fs_block_addr), 32'd76808);
    wait_start(3, "ws0", t3);
    chk("ws0_with_ct", 32'(st), 32'b1010);
    chk("ws0_addr", 32'(eng.ws_block_addr), 32'd0);
    chk("ws0_stride", 32'(eng.ws_row_stride), 32'd160);
    chk("ws0_owner", 32'(eng.sram_owner), 32'd1);

    // Skewed dones in MB plus a spurious fs_done
    @(negedge Clock); dly[1] = 3; dly[3] = 40;
    wait_start(3, "ws1", t3);
    chk("ws1_addr", 32'(eng.ws_block_addr), 32'd4);
    repeat (10) @(negedge Clock);
    inj_req++;
    wait_start(2, "cs_skew", t2);
    chk("skew_gap", 32'(t2 - t3), 32'd41);

    // Simultaneous dones in MB
    @(negedge Clock); dly[1] = 7; dly[3] = 7;
    wait_start(3, "ws2", t3);
    wait_start(2, "cs_sim", t2);
    chk("sim_gap", 32'(t2 - t3), 32'd8);
    @(negedge Clock); dly = '{5, 5, 5, 5};

    // Enable while busy must be ignored
    pulse_enable();

    seen = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      @(negedge Clock);
      if (done) begin seen = 1'b1; break; end
    end
    chk("done_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge Clock);
    chk("fs_count", 32'(st_cnt[0]), 32'd2400);
    chk("ct_count", 32'(st_cnt[1]), 32'd2400);
    chk("cs_count", 32'(st_cnt[2]), 32'd2400);
    chk("ws_count", 32'(st_cnt[3]), 32'd2400);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("fs_q_empty", 32'(fs_q.size()), 32'd0);
    chk("ws_q_empty", 32'(ws_q.size()), 32'd0);

    // Asynchronous reset in the middle of an MA phase
    push_run(2400);
    pulse_enable();
    wait_start(2, "cs_r1", t2);
    wait_start(2, "cs_r2", t2);
    @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_starts", 32'(st), 32'd0);
    chk("arst_fs_addr", 32'(eng.fs_block_addr), 32'd0);
    chk("arst_ws_addr", 32'(eng.ws_block_addr), 32'd0);
    chk("arst_fs_stride", 32'(eng.fs_row_stride), 32'd0);
    chk("arst_bank_owner", 32'({eng.dp_bank, eng.sram_owner}), 32'd0);
    fs_q.delete();
    ws_q.delete();
    repeat (10) @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    push_run(4);
    pulse_enable();
    chk("restart_fs_start", 32'(st), 32'd1);
    chk("restart_fs_addr", 32'(eng.fs_block_addr), 32'd76800);
    wait_start(3, "ws_restart", t3);
    chk("restart_ws_addr", 32'(eng.ws_block_addr), 32'd0);
    @(negedge Clock);
    Resetn = 1'b0;
    fs_q.delete();
    ws_q.delete();
    @(negedge Clock);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
